// File: rtl/ddr_burst_arbiter.sv
// rtl/ddr_burst_arbiter.sv - two-port round-robin arbiter in front of the DDR burst controller
//
// Shares one burst read/write interface between port 0 (icache) and port 1 (dcache).
// Exactly one burst is in flight at a time; the winner's address and length are latched
// into the downstream registers and beat strobes are routed to the granted port only.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   pN_rd_req / pN_wr_req          client burst requests, held until pN_done
//   pN_len, pN_addr                client burst length (beats) and start address
//   pN_wr_data / pN_wr_data_req    client write beat and its consume strobe
//   pN_rd_data / pN_rd_valid       read beat (broadcast) and per-port valid
//   pN_grant, pN_done              ownership flag and one-cycle completion pulse
//   rd_burst_* / wr_burst_*        downstream burst controller interface
//   len_err                        sticky beat-count mismatch flag
module ddr_burst_arbiter #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      p0_rd_req,
  input  logic                      p0_wr_req,
  input  logic [9:0]                p0_len,
  input  logic [DDR_ADDR_WIDTH-1:0] p0_addr,
  input  logic [DDR_DATA_WIDTH-1:0] p0_wr_data,
  output logic                      p0_wr_data_req,
  output logic [DDR_DATA_WIDTH-1:0] p0_rd_data,
  output logic                      p0_rd_valid,
  output logic                      p0_grant,
  output logic                      p0_done,
  input  logic                      p1_rd_req,
  input  logic                      p1_wr_req,
  input  logic [9:0]                p1_len,
  input  logic [DDR_ADDR_WIDTH-1:0] p1_addr,
  input  logic [DDR_DATA_WIDTH-1:0] p1_wr_data,
  output logic                      p1_wr_data_req,
  output logic [DDR_DATA_WIDTH-1:0] p1_rd_data,
  output logic                      p1_rd_valid,
  output logic                      p1_grant,
  output logic                      p1_done,
  output logic                      rd_burst_req,
  output logic                      wr_burst_req,
  output logic [9:0]                rd_burst_len,
  output logic [9:0]                wr_burst_len,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  output logic [DDR_DATA_WIDTH-1:0] wr_burst_data,
  input  logic                      wr_burst_data_req,
  input  logic                      rd_burst_data_valid,
  input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  input  logic                      rd_burst_finish,
  input  logic                      wr_burst_finish,
  output logic                      len_err
);

  typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY, DONE} state_t;

  state_t                    state, state_nx;
  logic                      ptr;     // last-granted port
  logic                      cur;     // port steering the data muxes; 0 out of reset
  logic [1:0]                grant;
  logic [9:0]                beats, beats_nx;
  logic                      cand0, cand1, any_req, win, win_rd;
  logic [9:0]                win_len;
  logic [DDR_ADDR_WIDTH-1:0] win_addr;
  logic                      do_grant, rd_beat, wr_beat, rd_fin, wr_fin;

  assign cand0    = p0_rd_req | p0_wr_req;
  assign cand1    = p1_rd_req | p1_wr_req;
  assign any_req  = cand0 | cand1;
  // On a tie the port that was not granted last wins.
  assign win      = (cand0 & cand1) ? ~ptr : cand1;
  // Read takes precedence when a port asks for both; the write stays pending.
  assign win_rd   = win ? p1_rd_req : p0_rd_req;
  assign win_len  = win ? p1_len : p0_len;
  assign win_addr = win ? p1_addr : p0_addr;

  assign do_grant = (state == IDLE) & any_req;
  assign rd_beat  = (state == RD_BUSY) & rd_burst_data_valid;
  assign wr_beat  = (state == WR_BUSY) & wr_burst_data_req;
  assign rd_fin   = (state == RD_BUSY) & rd_burst_finish;
  assign wr_fin   = (state == WR_BUSY) & wr_burst_finish;

  // Includes a beat arriving together with the finish strobe; saturates at 1023.
  assign beats_nx = ((rd_beat | wr_beat) && beats != 10'h3ff) ? beats + 10'd1 : beats;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = (win_len == 10'd0) ? DONE : (win_rd ? RD_BUSY : WR_BUSY);
      RD_BUSY: if (rd_burst_finish) state_nx = DONE;
      WR_BUSY: if (wr_burst_finish) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= 1'b1;
      cur           <= 1'b0;
      grant         <= 2'b00;
      beats         <= 10'd0;
      rd_burst_req  <= 1'b0;
      wr_burst_req  <= 1'b0;
      rd_burst_len  <= 10'd0;
      wr_burst_len  <= 10'd0;
      rd_burst_addr <= '0;
      wr_burst_addr <= '0;
      len_err       <= 1'b0;
    end else begin
      if (do_grant) begin
        ptr           <= win;
        cur           <= win;
        grant         <= win ? 2'b10 : 2'b01;
        beats         <= 10'd0;
        rd_burst_len  <= win_len;
        wr_burst_len  <= win_len;
        rd_burst_addr <= win_addr;
        wr_burst_addr <= win_addr;
        // Zero-length bursts never reach the controller.
        if (win_len != 10'd0) begin
          rd_burst_req <= win_rd;
          wr_burst_req <= ~win_rd;
        end
      end else begin
        beats <= beats_nx;
      end
      if (rd_fin) rd_burst_req <= 1'b0;
      if (wr_fin) wr_burst_req <= 1'b0;
      if ((rd_fin | wr_fin) && beats_nx != rd_burst_len) len_err <= 1'b1;
      if (state == DONE) grant <= 2'b00;
    end
  end

  assign p0_grant       = grant[0];
  assign p1_grant       = grant[1];
  assign p0_done        = (state == DONE) & grant[0];
  assign p1_done        = (state == DONE) & grant[1];
  assign p0_rd_data     = rd_burst_data;
  assign p1_rd_data     = rd_burst_data;
  assign p0_rd_valid    = rd_beat & ~cur;
  assign p1_rd_valid    = rd_beat & cur;
  assign p0_wr_data_req = wr_beat & ~cur;
  assign p1_wr_data_req = wr_beat & cur;
  assign wr_burst_data  = cur ? p1_wr_data : p0_wr_data;

endmodule
